// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit time-multiplexed scan controller.
//
// Parameters:
//   PRESCALE    clock cycles per digit slot (2..256)
//   BLANK       dark cycles at the start of each slot (0..PRESCALE-1)
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   rst         synchronous reset, active high
//   en          run enable; low holds the scan at digit 0, dark
//   load        one-cycle strobe that captures data
//   data        display word; digit k is data[4k+3:4k]
//   sel         digit index for the 2-to-4 digit decoder
//   nibble      value of the selected digit
//   blank       high when the selected digit must be dark
//   frame_done  one-cycle pulse in the first cycle of each frame
module display_scan_ctrl #(
    parameter int PRESCALE = 4,
    parameter int BLANK    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data,
    output logic [1:0]  sel,
    output logic [3:0]  nibble,
    output logic        blank,
    output logic        frame_done
);

    localparam int CW  = $clog2(PRESCALE);
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [CW:0]   BLANK_W = CW1'(BLANK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_v_q, pend_v_d;
    logic          frame_done_q, frame_done_d;
    logic          last_slot;
    logic          boundary;

    assign last_slot = (cnt_q == CNT_MAX);
    assign boundary  = last_slot && (sel_q == 2'd3);

    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_v_d     = pend_v_q;
        frame_done_d = 1'b0;

        if (rst) begin
            cnt_d     = '0;
            sel_d     = '0;
            shadow_d  = '0;
            pending_d = '0;
            pend_v_d  = 1'b0;
        end else if (!en) begin
            // Idle: no frame to tear, so words go straight to shadow.
            cnt_d = '0;
            sel_d = '0;
            if (load) begin
                shadow_d = data;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
                pend_v_d = 1'b0;
            end
        end else begin
            if (last_slot) begin
                cnt_d = '0;
                sel_d = sel_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (boundary) begin
                // A load on the boundary bypasses the pending buffer.
                frame_done_d = 1'b1;
                if (load) begin
                    shadow_d = data;
                    pend_v_d = 1'b0;
                end else if (pend_v_q) begin
                    shadow_d = pending_q;
                    pend_v_d = 1'b0;
                end
            end else if (load) begin
                pending_d = data;
                pend_v_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        cnt_q        <= cnt_d;
        sel_q        <= sel_d;
        shadow_q     <= shadow_d;
        pending_q    <= pending_d;
        pend_v_q     <= pend_v_d;
        frame_done_q <= frame_done_d;
    end

    // Outputs are forced to their reset values while rst is held so
    // the decoder sees a dark digit 0 even before the first edge.
    assign sel        = rst ? 2'd0 : sel_q;
    assign nibble     = rst ? 4'd0 : shadow_q[{sel_q, 2'b00} +: 4];
    assign blank      = ~en | rst | ({1'b0, cnt_q} < BLANK_W);
    assign frame_done = frame_done_q & ~rst;

endmodule
